// File: rtl/green_bullet_ctrl.sv
// green_bullet_ctrl: spawns, advances and resolves the green tank's single bullet
module green_bullet_ctrl #(
  parameter int TANK_SIZE   = 32,
  parameter int BULLET_SIZE = 4,
  parameter int STEP_CNT    = 250000,
  parameter int STEP_PX     = 2,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       fire,
  input  logic [1:0] bullet_orient,
  input  logic [9:0] x_tank,
  input  logic [8:0] y_tank,
  input  logic [9:0] x_target,
  input  logic [8:0] y_target,
  output logic       green_bullet_act,
  output logic [9:0] x_bullet,
  output logic [8:0] y_bullet,
  output logic       hit,
  output logic       miss
);
  localparam int CW = STEP_CNT > 1 ? $clog2(STEP_CNT) : 1;
  localparam logic [10:0] C  = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] TS = 11'(TANK_SIZE);
  localparam logic [10:0] BS = 11'(BULLET_SIZE);
  localparam logic [10:0] SP = 11'(STEP_PX);
  // Highest legal top-left coordinate; 11-bit underflow wraps far above these
  localparam logic [10:0] XL = 11'(X_MAX - BULLET_SIZE + 1);
  localparam logic [10:0] YL = 11'(Y_MAX - BULLET_SIZE + 1);
  typedef enum logic {IDLE, FLY} state_t;
  state_t state;
  logic [1:0] orient;
  logic [CW-1:0] cnt;
  logic [10:0] xt, yt, xb, yb, xg, yg, sx, sy, nx, ny;
  logic overlap;
  assign xt = {1'b0, x_tank};
  assign yt = {2'b0, y_tank};
  assign xb = {1'b0, x_bullet};
  assign yb = {2'b0, y_bullet};
  assign xg = {1'b0, x_target};
  assign yg = {2'b0, y_target};
  assign green_bullet_act = state == FLY;
  always_comb begin
    sx = bullet_orient[1] ? (bullet_orient[0] ? xt + TS : xt - BS) : xt + C;
    sy = bullet_orient[1] ? yt + C : (bullet_orient[0] ? yt + TS : yt - BS);
    nx = orient[1] ? (orient[0] ? xb + SP : xb - SP) : xb;
    ny = orient[1] ? yb : (orient[0] ? yb + SP : yb - SP);
    overlap = xb <= xg + TS - 11'd1 && xb + BS - 11'd1 >= xg &&
              yb <= yg + TS - 11'd1 && yb + BS - 11'd1 >= yg;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      orient   <= 2'b00;
      cnt      <= '0;
      x_bullet <= '0;
      y_bullet <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (run && state == IDLE && fire) begin
        orient <= bullet_orient;
        if (sx <= XL && sy <= YL) begin
          state    <= FLY;
          x_bullet <= sx[9:0];
          y_bullet <= sy[8:0];
          cnt      <= '0;
        end else
          miss <= 1'b1;
      end else if (run && state == FLY) begin
        if (overlap) begin
          state <= IDLE;
          hit   <= 1'b1;
        end else if (cnt == CW'(STEP_CNT - 1)) begin
          cnt <= '0;
          if (nx <= XL && ny <= YL) begin
            x_bullet <= nx[9:0];
            y_bullet <= ny[8:0];
          end else begin
            state <= IDLE;
            miss  <= 1'b1;
          end
        end else
          cnt <= cnt + CW'(1);
      end
    end
  end
endmodule
